// File: rtl/fp_add_sequencer_pkg.sv
// Float encoding, sequencer states and operand classification helpers for fp_add_sequencer.
package fp_add_sequencer_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} fp_seq_state_t;

  localparam logic [7:0]  MAXSHIFT = 8'd27;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam int          GRSBITS  = 3;
  localparam int          MANTBITS = 24;

  function automatic logic IsNaN(input float_t f);
    return (f.exp == 8'hFF) && (f.frac != '0);
  endfunction

  function automatic logic IsInf(input float_t f);
    return (f.exp == 8'hFF) && (f.frac == '0);
  endfunction

  function automatic logic IsZero(input float_t f);
    return (f.exp == 8'h00) && (f.frac == '0);
  endfunction

  function automatic logic IsDenorm(input float_t f);
    return (f.exp == 8'h00) && (f.frac != '0);
  endfunction

endpackage

// File: rtl/fp_special_case.sv
// Purpose: resolves NaN/Inf/zero/denorm operand pairs without the arithmetic datapath.
// Latency: combinational.
// Backpressure: none; pure function of a and b.
module fp_special_case
  import fp_add_sequencer_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_special,
  output logic [31:0] special_sum,
  output logic        special_invalid
);

  float_t fa, fb;
  logic   a_zero, b_zero;

  assign fa = a;
  assign fb = b;
  // Denormals are flushed, so they behave exactly like signed zeros here.
  assign a_zero = IsZero(fa) | IsDenorm(fa);
  assign b_zero = IsZero(fb) | IsDenorm(fb);

  assign is_special = IsNaN(fa) | IsNaN(fb) | IsInf(fa) | IsInf(fb) | a_zero | b_zero;

  always_comb begin
    special_sum     = a;
    special_invalid = 1'b0;
    if (IsNaN(fa) || IsNaN(fb)) begin
      special_sum = QNAN;
    end else if (IsInf(fa) && IsInf(fb)) begin
      if (fa.sign != fb.sign) begin
        special_sum     = QNAN;
        special_invalid = 1'b1;
      end
    end else if (IsInf(fb)) begin
      special_sum = b;
    end else if (IsInf(fa)) begin
      special_sum = a;
    end else if (a_zero && b_zero) begin
      special_sum = {fa.sign & fb.sign, 31'b0};
    end else if (a_zero) begin
      special_sum = b;
    end
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// Purpose: multi-cycle single-precision adder (align/add/normalise/round); FP_RNE_EN selects RNE vs truncate.
// Latency: special operands 1 cycle; otherwise 4 + max(1,k) cycles, k = left-normalisation shifts.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module fp_add_sequencer
  import fp_add_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        resetN,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic [2:0]  flags,
  output logic        busy
);

  localparam int MW = MANTBITS + GRSBITS;

`ifdef FP_RNE_EN
  localparam logic [30:0] OVF_MAG = 31'h7F80_0000;
`else
  localparam logic [30:0] OVF_MAG = 31'h7F7F_FFFF;
`endif

  fp_seq_state_t   state_q, state_d;
  float_t          a_q, a_d, b_q, b_d;
  logic [MW-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic [MW:0]     m_q, m_d;
  logic [8:0]      exp_q, exp_d;
  logic            sign_q, sign_d, sub_q, sub_d;
  logic [31:0]     sum_q, sum_d;
  logic [2:0]      flags_q, flags_d;

  logic            is_special, special_invalid;
  logic [31:0]     special_sum;

  fp_special_case u_special (
    .a               (a),
    .b               (b),
    .is_special      (is_special),
    .special_sum     (special_sum),
    .special_invalid (special_invalid)
  );

  // Alignment: larger magnitude becomes A, B shifted right with sticky collapse.
  logic            swap;
  float_t          big;
  logic [7:0]      small_exp, exp_diff, shamt;
  logic [22:0]     small_frac;
  logic [2*MW-1:0] b_wide;
  logic [MW-1:0]   mb_aligned;

  assign swap       = {b_q.exp, b_q.frac} > {a_q.exp, a_q.frac};
  assign big        = swap ? b_q : a_q;
  assign small_exp  = swap ? a_q.exp : b_q.exp;
  assign small_frac = swap ? a_q.frac : b_q.frac;
  assign exp_diff   = big.exp - small_exp;
  assign shamt      = (exp_diff > MAXSHIFT) ? MAXSHIFT : exp_diff;
  assign b_wide     = {1'b1, small_frac, {GRSBITS{1'b0}}, {MW{1'b0}}} >> shamt;
  assign mb_aligned = b_wide[2*MW-1:MW] | {{(MW-1){1'b0}}, |b_wide[MW-1:0]};

  // Rounding on the normalised mantissa; m_q[2:0] are guard/round/sticky.
  logic              round_up, inexact;
  logic [MANTBITS:0] mant_r;
  logic [8:0]        exp_r;
  logic [22:0]       frac_r;

  assign inexact = |m_q[2:0];
`ifdef FP_RNE_EN
  assign round_up = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
`else
  assign round_up = 1'b0;
`endif
  assign mant_r = {1'b0, m_q[MW-1:GRSBITS]} + {{MANTBITS{1'b0}}, round_up};
  assign exp_r  = exp_q + {8'b0, mant_r[MANTBITS]};
  assign frac_r = mant_r[MANTBITS] ? mant_r[23:1] : mant_r[22:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    m_d     = m_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = a;
          b_d = b;
          if (is_special) begin
            sum_d   = special_sum;
            flags_d = {special_invalid, 2'b00};
            state_d = DONE;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        ma_d    = {1'b1, big.frac, {GRSBITS{1'b0}}};
        mb_d    = mb_aligned;
        exp_d   = {1'b0, big.exp};
        sign_d  = big.sign;
        sub_d   = a_q.sign ^ b_q.sign;
        state_d = ADD;
      end
      ADD: begin
        m_d     = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
        state_d = NORM;
      end
      NORM: begin
        if (m_q[MW]) begin
          m_d     = {1'b0, m_q[MW:2], m_q[1] | m_q[0]};
          exp_d   = exp_q + 9'd1;
          state_d = ROUND;
        end else if (m_q == '0) begin
          sum_d   = '0;
          flags_d = 3'b000;
          state_d = DONE;
        end else if (m_q[MW-1]) begin
          state_d = ROUND;
        end else if (exp_q == 9'd1) begin
          sum_d   = {sign_q, 31'b0};
          flags_d = 3'b001;
          state_d = DONE;
        end else begin
          // The last shift goes straight to ROUND so k shifts cost k cycles.
          m_d   = {m_q[MW-1:0], 1'b0};
          exp_d = exp_q - 9'd1;
          if (m_q[MW-2]) state_d = ROUND;
        end
      end
      ROUND: begin
        if (exp_r >= 9'd255) begin
          sum_d   = {sign_q, OVF_MAG};
          flags_d = 3'b011;
        end else begin
          sum_d   = {sign_q, exp_r[7:0], frac_r};
          flags_d = {2'b00, inexact};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      m_q     <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      m_q     <= m_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign flags     = flags_q;

endmodule
